// File: rtl/wshb_fb_ram.sv
// -----------------------------------------------------------------------------
// wshb_fb_ram
//
// Wishbone B4 slave wrapping an on-chip 32-bit framebuffer/scratch RAM. It
// stands in for the SDRAM path during bring-up: same registered-feedback
// timing, one wait state on the first beat, then one beat per cycle for
// linear incrementing bursts.
//
// Handshake: a request is cyc&stb. The responder answers with exactly one of
// ack/err for a beat; a beat is complete on the edge where the response is
// high and cyc&stb is still high. Writes commit only on such an acked edge.
// dat_sm is meaningful only while ack is high.
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   cyc, stb, we         Wishbone cycle, strobe, write enable
//   adr[31:0]            byte address (word index = adr[ADDR_WIDTH+1:2])
//   sel[3:0]             byte enables for writes
//   dat_ms[31:0]         write data from the initiator
//   cti[2:0], bte[1:0]   cycle type / burst type tags
//   dat_sm[31:0]         read data to the initiator
//   ack, err, rty        termination signals (rty is never used)
//   dbg_state_o[1:0]     current FSM state (0 IDLE, 1 SINGLE, 2 BURST)
// -----------------------------------------------------------------------------
module wshb_fb_ram #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DEPTH_WORDS = 2**ADDR_WIDTH
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty,
  output logic [1:0]  dbg_state_o
);

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;
  localparam logic [1:0] BTE_LIN  = 2'b00;

  // Depth expressed with one extra bit so an incremented index that walks
  // off the end of a full-depth array can still be compared.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH_WORDS[ADDR_WIDTH:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [31:0]             dat_q, dat_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic [31:0]             mem_q [DEPTH_WORDS];

  logic                    req;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    req_in_range;
  logic                    req_burst;
  logic [ADDR_WIDTH:0]     next_idx;
  logic                    wr_en;

  // adr[1:0] selects a byte within a word and is deliberately ignored.
  logic unused_adr;
  assign unused_adr = ^adr[1:0];

  assign req          = cyc & stb;
  assign req_idx      = adr[ADDR_WIDTH+1:2];
  // Upper address bits must be zero; the lower index must also fall inside
  // the implemented depth when DEPTH_WORDS is not a power of two.
  assign req_in_range = (adr[31:ADDR_WIDTH+2] == '0) &&
                        ({1'b0, req_idx} < DEPTH_L);
  assign req_burst    = (cti == CTI_INCR) && (bte == BTE_LIN);
  assign next_idx     = {1'b0, addr_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Next-state / response logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    addr_d  = addr_q;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = req_idx;
          if (req_in_range) begin
            ack_d = 1'b1;
            if (!we) begin
              dat_d = mem_q[req_idx];
            end
            state_d = req_burst ? ST_BURST : ST_SINGLE;
          end else begin
            err_d   = 1'b1;
            dat_d   = '0;
            state_d = ST_SINGLE;
          end
        end
      end

      // Response cycle of a single access (or of any err). The response
      // always drops afterwards, which forces the idle cycle between singles.
      ST_SINGLE: begin
        wr_en   = ack_q & req & we;
        state_d = ST_IDLE;
      end

      // ack is high throughout this state; each edge with cyc&stb completes
      // a beat. Read data for the following word is fetched on that edge so
      // it is already present when ack stays high for the next beat.
      ST_BURST: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          wr_en = we;
          if (cti == CTI_EOB) begin
            state_d = ST_IDLE;
          end else if (next_idx >= DEPTH_L) begin
            err_d   = 1'b1;
            dat_d   = '0;
            state_d = ST_SINGLE;
          end else begin
            ack_d  = 1'b1;
            addr_d = next_idx[ADDR_WIDTH-1:0];
            if (!we) begin
              dat_d = mem_q[next_idx[ADDR_WIDTH-1:0]];
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      addr_q  <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM array: contents survive reset, byte-lane writes at the beat address.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) begin
          mem_q[addr_q][8*b +: 8] <= dat_ms[8*b +: 8];
        end
      end
    end
  end

  assign dat_sm      = dat_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign rty         = 1'b0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wshb_fb_ram.sv
// -----------------------------------------------------------------------------
// tb_wshb_fb_ram
//
// Directed bench for wshb_fb_ram: a table of single accesses with
// hand-computed responses, followed by hand-written burst, stall, error,
// abort and reset sequences.
// -----------------------------------------------------------------------------
module tb_wshb_fb_ram;

  localparam int AW = 10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        sys_clk;
  logic        sys_rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack, err, rty;
  logic [1:0]  dbg_state;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  wshb_fb_ram #(.ADDR_WIDTH(AW)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cyc         (cyc),
    .stb         (stb),
    .we          (we),
    .adr         (adr),
    .sel         (sel),
    .dat_ms      (dat_ms),
    .cti         (cti),
    .bte         (bte),
    .dat_sm      (dat_sm),
    .ack         (ack),
    .err         (err),
    .rty         (rty),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat_ms = '0; cti = 3'b000; bte = 2'b00;
  endtask

  task automatic bus_drive(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [2:0] c, input logic [1:0] b);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; sel = s; dat_ms = d; cti = c; bte = b;
  endtask

  // One complete single access. Called at posedge+1; returns at posedge+1 with
  // the bus released and the cycle after the response observed.
  task automatic wb_single(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [2:0] c, input logic [1:0] b,
                           output logic r_ack, output logic r_err, output logic [31:0] r_dat,
                           output logic i_ack, output logic i_err);
    bus_drive(w, a, s, d, c, b);
    @(posedge sys_clk); #1;
    r_ack = ack; r_err = err; r_dat = dat_sm;
    @(posedge sys_clk); #1;
    i_ack = ack; i_err = err;
    bus_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [2:0]  c;
    logic [1:0]  b;
    logic        e_ack;
    logic        e_err;
    logic        chk_dat;
    logic [31:0] e_dat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  logic        r_ack, r_err, i_ack, i_err;
  logic [31:0] r_dat;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we    adr           sel   wdata          cti     bte    ack   err   chk   rdata
    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'hAAAAAAAA, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'h11223344, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,        3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'hAA22AA44};
    // word index DEPTH_WORDS: error, read data forced to zero
    vecs[5]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,        3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0};
    // out-of-range write that would alias word 4 if upper bits were ignored
    vecs[6]  = '{1'b1, 32'h0000_1010, 4'hF, 32'h12345678, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h8000_0010, 4'hF, 32'h0,        3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0};
    // adr[1:0] ignored; also shows word 4 was not hit by vector 6
    vecs[8]  = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,        3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h0BADF00D, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,        3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0BADF00D};
    // incrementing tag with non-linear bte, and a reserved cti: both single
    vecs[11] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,        3'b010, 2'b01, 1'b1, 1'b0, 1'b1, 32'hAA22AA44};
    vecs[12] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        3'b011, 2'b00, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};

    // ---- reset state --------------------------------------------------------
    bus_idle();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_ack", ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_dat", dat_sm, 32'h0);
    check("rst_rty", rty, 1'b0);
    check("rst_state", dbg_state, S_IDLE);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("idle_no_ack", ack, 1'b0);

    // ---- table of single accesses ------------------------------------------
    for (int i = 0; i < NV; i++) begin
      wb_single(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].c, vecs[i].b,
                r_ack, r_err, r_dat, i_ack, i_err);
      check($sformatf("v%0d_ack", i), r_ack, vecs[i].e_ack);
      check($sformatf("v%0d_err", i), r_err, vecs[i].e_err);
      if (vecs[i].chk_dat) check($sformatf("v%0d_dat", i), r_dat, vecs[i].e_dat);
      check($sformatf("v%0d_gap_ack", i), i_ack, 1'b0);
      check($sformatf("v%0d_gap_err", i), i_err, 1'b0);
    end

    // ---- back-to-back singles with stb held: ack must drop for a cycle ------
    bus_drive(1'b0, 32'h10, 4'hF, 32'h0, 3'b000, 2'b00);
    @(posedge sys_clk); #1;
    check("b2b_ack0", ack, 1'b1);
    check("b2b_dat0", dat_sm, 32'hDEADBEEF);
    @(posedge sys_clk); #1;
    adr = 32'h20;
    check("b2b_gap", ack, 1'b0);
    @(posedge sys_clk); #1;
    check("b2b_ack1", ack, 1'b1);
    check("b2b_dat1", dat_sm, 32'hAA22AA44);
    @(posedge sys_clk); #1;
    bus_idle();

    // ---- preload words 0..7 with their own index ---------------------------
    for (int k = 0; k < 8; k++) begin
      wb_single(1'b1, 32'(k * 4), 4'hF, 32'(k), 3'b000, 2'b00, r_ack, r_err, r_dat, i_ack, i_err);
      check($sformatf("pre%0d_ack", k), r_ack, 1'b1);
    end

    // ---- 8-beat read burst --------------------------------------------------
    bus_drive(1'b0, 32'h0, 4'hF, 32'h0, 3'b010, 2'b00);
    @(posedge sys_clk); #1;
    check("rb0_ack", ack, 1'b1);
    check("rb0_dat", dat_sm, 32'd0);
    check("rb_state", dbg_state, S_BURST);
    for (int k = 1; k < 8; k++) begin
      @(posedge sys_clk); #1;
      adr = 32'(k * 4);
      cti = (k == 7) ? 3'b111 : 3'b010;
      check($sformatf("rb%0d_ack", k), ack, 1'b1);
      check($sformatf("rb%0d_dat", k), dat_sm, 32'(k));
    end
    @(posedge sys_clk); #1;
    check("rb_end_ack", ack, 1'b0);
    check("rb_end_state", dbg_state, S_IDLE);
    bus_idle();
    @(posedge sys_clk); #1;

    // ---- stalled burst: three beats, stb low two cycles, resume at 0x0C -----
    bus_drive(1'b0, 32'h0, 4'hF, 32'h0, 3'b010, 2'b00);
    @(posedge sys_clk); #1;
    check("st0_dat", dat_sm, 32'd0);
    for (int k = 1; k < 3; k++) begin
      @(posedge sys_clk); #1;
      adr = 32'(k * 4);
      check($sformatf("st%0d_ack", k), ack, 1'b1);
      check($sformatf("st%0d_dat", k), dat_sm, 32'(k));
    end
    @(posedge sys_clk); #1;
    stb = 1'b0;
    @(posedge sys_clk); #1;
    check("st_drop_ack", ack, 1'b0);
    @(posedge sys_clk); #1;
    check("st_drop2_ack", ack, 1'b0);
    stb = 1'b1; adr = 32'h0C; cti = 3'b010;
    @(posedge sys_clk); #1;
    check("st_resume_ack", ack, 1'b1);
    check("st_resume_dat", dat_sm, 32'd3);
    @(posedge sys_clk); #1;
    adr = 32'h10; cti = 3'b111;
    check("st_next_ack", ack, 1'b1);
    check("st_next_dat", dat_sm, 32'd4);
    @(posedge sys_clk); #1;
    check("st_end_ack", ack, 1'b0);
    bus_idle();
    @(posedge sys_clk); #1;

    // ---- write burst crossing the last word --------------------------------
    bus_drive(1'b1, 32'hFF8, 4'hF, 32'hA0A0A0A0, 3'b010, 2'b00);
    @(posedge sys_clk); #1;
    check("ov0_ack", ack, 1'b1);
    @(posedge sys_clk); #1;
    adr = 32'hFFC; dat_ms = 32'hB1B1B1B1;
    check("ov1_ack", ack, 1'b1);
    @(posedge sys_clk); #1;
    adr = 32'h1000; dat_ms = 32'hC2C2C2C2;
    check("ov2_err", err, 1'b1);
    check("ov2_ack", ack, 1'b0);
    check("ov2_dat", dat_sm, 32'h0);
    @(posedge sys_clk); #1;
    check("ov3_err", err, 1'b0);
    check("ov3_ack", ack, 1'b0);
    bus_idle();
    wb_single(1'b0, 32'hFF8, 4'hF, 32'h0, 3'b000, 2'b00, r_ack, r_err, r_dat, i_ack, i_err);
    check("ov_rd1022", r_dat, 32'hA0A0A0A0);
    wb_single(1'b0, 32'hFFC, 4'hF, 32'h0, 3'b000, 2'b00, r_ack, r_err, r_dat, i_ack, i_err);
    check("ov_rd1023", r_dat, 32'hB1B1B1B1);
    wb_single(1'b0, 32'h0, 4'hF, 32'h0, 3'b000, 2'b00, r_ack, r_err, r_dat, i_ack, i_err);
    check("ov_rd0", r_dat, 32'd0);

    // ---- cyc dropped while ack is high: write must not commit -------------
    wb_single(1'b1, 32'h40, 4'hF, 32'h01020304, 3'b000, 2'b00, r_ack, r_err, r_dat, i_ack, i_err);
    bus_drive(1'b1, 32'h40, 4'hF, 32'h99999999, 3'b000, 2'b00);
    @(posedge sys_clk); #1;
    check("ab_ack", ack, 1'b1);
    bus_idle();
    @(posedge sys_clk); #1;
    check("ab_state", dbg_state, S_IDLE);
    wb_single(1'b0, 32'h40, 4'hF, 32'h0, 3'b000, 2'b00, r_ack, r_err, r_dat, i_ack, i_err);
    check("ab_rd", r_dat, 32'h01020304);

    // ---- asynchronous reset in the middle of a burst -----------------------
    bus_drive(1'b0, 32'h0, 4'hF, 32'h0, 3'b010, 2'b00);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    adr = 32'h4;
    check("mr_pre_dat", dat_sm, 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("mr_ack", ack, 1'b0);
    check("mr_err", err, 1'b0);
    check("mr_dat", dat_sm, 32'h0);
    check("mr_state", dbg_state, S_IDLE);
    bus_idle();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge sys_clk); #1;
      check($sformatf("mr_idle%0d_ack", k), ack, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
